oam_dma: RTL and testbench

Sprite-attribute DMA engine sitting directly downstream of the `cpu` bus port and upstream of the memory/IO fabric. It snoops CPU writes to the DMA register at 0xFF46, then takes over the memory bus to copy 160 bytes from `{src_hi, 8'h00}` into OAM, one byte per 4-clock machine cycle. While it runs, CPU accesses outside HRAM are blocked.

---
 rtl/oam_dma_pkg.sv | 21 ++
 rtl/oam_dma_bus_mux.sv | 55 +++++
 rtl/oam_dma.sv | 144 ++++++++++++++
 tb/tb_oam_dma.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared constants and state encoding for the OAM DMA engine.
// Optional echo-RAM source remap is enabled by defining OAM_DMA_ECHO_REMAP_EN.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;

  localparam int unsigned OAM_LEN_DEFAULT = 160;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StXfer  = 2'd2
  } dma_state_e;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational bus arbitration between the CPU port and the DMA engine.
// Selects mem_* and cpu_rdata from the DMA state and the CPU address.
module oam_dma_bus_mux
  import oam_dma_pkg::*;
(
  input  logic        i_xfer,
  input  logic        i_dma_rd,
  input  logic [15:0] i_dma_a,
  input  logic [7:0]  i_src_hi,
  input  logic [15:0] i_cpu_a,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  output logic [7:0]  o_cpu_rdata,
  output logic [15:0] o_mem_a,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata
);

  logic w_is_reg;
  logic w_is_hram;

  assign w_is_reg  = (i_cpu_a == DMA_REG_ADDR);
  assign w_is_hram = is_hram(i_cpu_a);

  always_comb begin
    o_mem_a     = i_cpu_a;
    o_mem_wdata = i_cpu_wdata;
    o_mem_rd    = i_cpu_rd;
    o_mem_wr    = i_cpu_wr;
    o_cpu_rdata = i_mem_rdata;

    if (i_xfer) begin
      if (i_dma_rd) begin
        o_mem_a  = i_dma_a;
        o_mem_rd = 1'b1;
        o_mem_wr = 1'b0;
      end else if (!w_is_hram) begin
        // Non-HRAM CPU traffic is blocked for the whole transfer.
        o_mem_rd = 1'b0;
        o_mem_wr = 1'b0;
      end
      if (!w_is_hram || i_dma_rd) begin
        o_cpu_rdata = 8'hFF;
      end
    end

    if (w_is_reg) begin
      o_cpu_rdata = i_src_hi;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to 0xFF46 and copies OAM_LEN bytes into OAM.
// Define OAM_DMA_ECHO_REMAP_EN to fold echo-RAM sources (0xE0-0xFF) onto WRAM.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned CLKS_PER_BYTE = 4,
  parameter int unsigned OAM_LEN       = OAM_LEN_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_a,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  output logic [7:0]  o_cpu_rdata,
  output logic [15:0] o_mem_a,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  output logic [7:0]  o_oam_a,
  output logic [7:0]  o_oam_wdata,
  output logic        o_oam_we,
  output logic        o_busy
);

  localparam int unsigned PhW = $clog2(CLKS_PER_BYTE);
  localparam logic [PhW-1:0] LastPh   = PhW'(CLKS_PER_BYTE - 1);
  localparam logic [PhW-1:0] RdLastPh = PhW'(CLKS_PER_BYTE - 2);
  localparam logic [7:0]     LastIdx  = 8'(OAM_LEN - 1);

  dma_state_e     r_state, w_state_d;
  logic [PhW-1:0] r_phase, w_phase_d;
  logic [7:0]     r_idx, w_idx_d;
  logic [7:0]     r_src_hi, w_src_hi_d;
  logic [7:0]     r_latch, w_latch_d;
  logic           r_wr_q;

  logic           w_trig;
  logic           w_xfer;
  logic           w_dma_rd;
  logic [7:0]     w_src_eff;
  logic [15:0]    w_dma_a;

  assign w_trig = i_cpu_wr && !r_wr_q && (i_cpu_a == DMA_REG_ADDR);

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign w_src_eff = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;
`else
  assign w_src_eff = r_src_hi;
`endif

  assign w_dma_a = {w_src_eff, r_idx};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_phase  <= '0;
      r_idx    <= '0;
      r_src_hi <= 8'hFF;
      r_latch  <= '0;
      r_wr_q   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_phase  <= w_phase_d;
      r_idx    <= w_idx_d;
      r_src_hi <= w_src_hi_d;
      r_latch  <= w_latch_d;
      r_wr_q   <= i_cpu_wr;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_phase_d  = r_phase;
    w_idx_d    = r_idx;
    w_src_hi_d = r_src_hi;
    w_latch_d  = r_latch;

    // A trigger restarts from any state; bytes already in OAM stay written.
    if (w_trig) begin
      w_src_hi_d = i_cpu_wdata;
      w_state_d  = StStart;
      w_phase_d  = '0;
      w_idx_d    = '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StStart: begin
          if (r_phase == LastPh) begin
            w_state_d = StXfer;
            w_phase_d = '0;
          end else begin
            w_phase_d = r_phase + 1'b1;
          end
        end
        StXfer: begin
          if (r_phase == LastPh) begin
            w_phase_d = '0;
            if (r_idx == LastIdx) begin
              w_state_d = StIdle;
              w_idx_d   = '0;
            end else begin
              w_idx_d = r_idx + 8'd1;
            end
          end else begin
            w_phase_d = r_phase + 1'b1;
            if (r_phase == RdLastPh) begin
              w_latch_d = i_mem_rdata;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_xfer      = (r_state == StXfer);
    w_dma_rd    = w_xfer && (r_phase != '0) && (r_phase != LastPh);
    o_oam_we    = w_xfer && (r_phase == LastPh);
    o_oam_a     = r_idx;
    o_oam_wdata = r_latch;
    o_busy      = (r_state != StIdle);
  end

  oam_dma_bus_mux u_bus_mux (
    .i_xfer      (w_xfer),
    .i_dma_rd    (w_dma_rd),
    .i_dma_a     (w_dma_a),
    .i_src_hi    (r_src_hi),
    .i_cpu_a     (i_cpu_a),
    .i_cpu_wdata (i_cpu_wdata),
    .i_cpu_rd    (i_cpu_rd),
    .i_cpu_wr    (i_cpu_wr),
    .o_cpu_rdata (o_cpu_rdata),
    .o_mem_a     (o_mem_a),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .i_mem_rdata (i_mem_rdata)
  );

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected OAM writes are queued at trigger time
// and popped as oam_we pulses appear.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_a;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        busy;

  oam_dma dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_a     (cpu_a),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_rd    (cpu_rd),
    .i_cpu_wr    (cpu_wr),
    .o_cpu_rdata (cpu_rdata),
    .o_mem_a     (mem_a),
    .o_mem_wdata (mem_wdata),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .i_mem_rdata (mem_rdata),
    .o_oam_a     (oam_a),
    .o_oam_wdata (oam_wdata),
    .o_oam_we    (oam_we),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten locations hold a fixed address pattern (0xC1xx = xx ^ 0x5A).
  logic [7:0] mem [0:65535];
  bit         mem_vld [0:65535];
  logic [7:0] oam [0:255];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  always_comb mem_rdata = mem_vld[mem_a] ? mem[mem_a] : init_val(mem_a);

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_a]     <= mem_wdata;
      mem_vld[mem_a] <= 1'b1;
    end
  end

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return mem_vld[a] ? mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] src_eff(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_REMAP_EN
    return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
    return s;
`endif
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  busy_cnt = 0;
  int  we_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (oam_we) begin
        we_cnt++;
        oam[oam_a] = oam_wdata;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_oam_we", 32'(oam_we), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("oam_a", 32'(oam_a), 32'(e.a));
          check_eq("oam_wdata", 32'(oam_wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic trigger(input logic [7:0] src, input int hold);
    @(posedge clk); #1;
    cpu_a     = 16'hFF46;
    cpu_wdata = src;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 160; i++) begin
      sb_q.push_back('{a: 8'(i), d: mem_val({src_eff(src), 8'(i)})});
    end
    @(posedge clk); #1;
    busy_cnt = 0;
    we_cnt   = 0;
    repeat (hold - 1) @(posedge clk);
    if (hold > 1) #1;
    cpu_wr = 1'b0;
    cpu_a  = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_busy_len"}, 32'(busy_cnt), 32'd644);
    check_eq({tag, "_we_cnt"}, 32'(we_cnt), 32'd160);
  endtask

  task automatic wait_oam(input logic [7:0] idx);
    for (int i = 0; i < 1000 && !(oam_we && oam_a == idx); i++) @(negedge clk);
    check_eq("wait_oam_we", 32'(oam_we), 32'd1);
    check_eq("wait_oam_a", 32'(oam_a), 32'(idx));
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cpu_a  = 16'hFF46;
    cpu_rd = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_oam_we", 32'(oam_we), 32'd0);
    check_eq("rst_src_hi", 32'(cpu_rdata), 32'hFF);
    check_eq("rst_mem_rd_pass", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    cpu_a = 16'hC005;
    @(negedge clk);
    check_eq("idle_pass_rdata", 32'(cpu_rdata), 32'(init_val(16'hC005)));
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_a  = 16'h0000;

    // Basic transfer from 0xC100 with CPU traffic during XFER
    trigger(8'hC1, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) break;
      n++;
    end
    check_eq("first_mem_rd_cycle", 32'(n), 32'd6);
    check_eq("first_mem_a", 32'(mem_a), 32'hC100);
    @(posedge clk); #1;
    cpu_a  = 16'hC000;
    cpu_rd = 1'b1;
    @(negedge clk);
    check_eq("xfer_blocked_rd", 32'(cpu_rdata), 32'hFF);
    @(posedge clk); #1;
    cpu_rd    = 1'b0;
    cpu_wdata = 8'h12;
    cpu_wr    = 1'b1;
    repeat (4) @(posedge clk);
    #1 cpu_wr = 1'b0;
    check_eq("xfer_blocked_wr", 32'(mem_val(16'hC000)), 32'(init_val(16'hC000)));
    @(posedge clk); #1;
    cpu_a     = 16'hFF90;
    cpu_wdata = 8'h77;
    cpu_wr    = 1'b1;
    repeat (4) @(posedge clk);
    #1 cpu_wr = 1'b0;
    check_eq("hram_wr", 32'(mem_val(16'hFF90)), 32'h77);
    cpu_rd = 1'b1;
    for (int i = 0; i < 8 && !oam_we; i++) @(negedge clk);
    check_eq("hram_rd", 32'(cpu_rdata), 32'h77);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_a  = 16'h0000;
    wait_idle("basic");
    check_eq("basic_oam_0", 32'(oam[0]), 32'h5A);
    check_eq("basic_oam_159", 32'(oam[159]), 32'(8'd159 ^ 8'h5A));

    // Retrigger at idx 80 with a new source
    trigger(8'hC1, 1);
    wait_oam(8'd79);
    trigger(8'hD0, 1);
    wait_idle("retrig");
    check_eq("retrig_oam_0", 32'(oam[0]), 32'(mem_val(16'hD000)));
    check_eq("retrig_oam_80", 32'(oam[80]), 32'(mem_val(16'hD050)));
    check_eq("retrig_oam_159", 32'(oam[159]), 32'(mem_val(16'hD09F)));

    // Echo-range source
    trigger(8'hE1, 1);
    for (int i = 0; i < 20 && !mem_rd; i++) @(negedge clk);
    check_eq("echo_first_mem_a", 32'(mem_a), 32'({src_eff(8'hE1), 8'h00}));
    wait_idle("echo");

    // Held write strobe: single trigger
    trigger(8'hC1, 2);
    wait_idle("hold2");

    // Reset mid-transfer
    trigger(8'hC1, 1);
    wait_oam(8'd49);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_oam_we", 32'(oam_we), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    cpu_a  = 16'hFF46;
    cpu_rd = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("midrst_readback", 32'(cpu_rdata), 32'hFF);
    check_eq("midrst_still_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
